// File: rtl/board_state_arbiter_if.sv
// Board-memory access bundle: video read port, game req/ack port and status flags.
// The arbiter takes the slave side; the requesters take the master side.
interface board_state_arbiter_if;
  logic       vid_req;
  logic [5:0] vid_addr;
  logic [3:0] vid_data;
  logic       vid_valid;
  logic       gl_req;
  logic       gl_we;
  logic [5:0] gl_addr;
  logic [3:0] gl_wdata;
  logic       gl_ack;
  logic [3:0] gl_rdata;
  logic       busy;
  logic       gl_stall_err;

  modport master (
    output vid_req, vid_addr, gl_req, gl_we, gl_addr, gl_wdata,
    input  vid_data, vid_valid, gl_ack, gl_rdata, busy, gl_stall_err
  );

  modport slave (
    input  vid_req, vid_addr, gl_req, gl_we, gl_addr, gl_wdata,
    output vid_data, vid_valid, gl_ack, gl_rdata, busy, gl_stall_err
  );
endinterface

// File: rtl/board_state_arbiter.sv
// 64x4 board memory: video reads win every cycle (1-cycle latency), game req/ack waits behind video.
// Macro BOARD_INIT_EN: reset runs a 64-cycle start-position load with busy high; otherwise reset clears the board.
module board_state_arbiter #(
  parameter int STALL_LIMIT = 800
) (
  input logic                  vga_clk,
  input logic                  reset,
  board_state_arbiter_if.slave bus
);

  localparam int            SW        = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

  logic [3:0]    mem_q [64];
  logic          mem_we;
  logic [5:0]    mem_waddr;
  logic [3:0]    mem_wdata;

  logic          vid_valid_q, vid_valid_d;
  logic [3:0]    vid_data_q,  vid_data_d;
  logic          gl_ack_q,    gl_ack_d;
  logic [3:0]    gl_rdata_q,  gl_rdata_d;
  logic [SW-1:0] stall_q,     stall_d;
  logic          stall_err_q, stall_err_d;
  logic          in_run;
  logic          gl_grant;

`ifdef BOARD_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e     state_q, state_d;
  logic [5:0] init_cnt_q, init_cnt_d;

  // Square code of the opening position: rank picks colour/pawns, file picks the back-rank piece.
  function automatic logic [3:0] start_code(input logic [5:0] sq);
    logic [2:0] kind;
    logic [3:0] code;
    case (sq[2:0])
      3'd0, 3'd7: kind = 3'd4;
      3'd1, 3'd6: kind = 3'd2;
      3'd2, 3'd5: kind = 3'd3;
      3'd3:       kind = 3'd5;
      default:    kind = 3'd6;
    endcase
    case (sq[5:3])
      3'd0:    code = {1'b1, kind};
      3'd1:    code = 4'h9;
      3'd6:    code = 4'h1;
      3'd7:    code = {1'b0, kind};
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 6'd1;
      if (init_cnt_q == 6'd63) begin
        state_d = ST_RUN;
      end
    end
  end

  assign in_run   = (state_q == ST_RUN);
  assign bus.busy = (state_q == ST_INIT);
`else
  assign in_run   = 1'b1;
  assign bus.busy = 1'b0;
`endif

  // Game is served only on cycles video leaves idle, and never on the cycle its ack is showing.
  assign gl_grant = !reset && in_run && !bus.vid_req && bus.gl_req && !gl_ack_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.gl_addr;
    mem_wdata = bus.gl_wdata;
    if (gl_grant && bus.gl_we) begin
      mem_we = 1'b1;
    end
`ifdef BOARD_INIT_EN
    if (!reset && state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt_q;
      mem_wdata = start_code(init_cnt_q);
    end
`endif
  end

  always_ff @(posedge vga_clk) begin
`ifdef BOARD_INIT_EN
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
`else
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
`endif
  end

  always_comb begin
    vid_valid_d = bus.vid_req;
    vid_data_d  = vid_data_q;
    gl_ack_d    = gl_grant;
    gl_rdata_d  = gl_rdata_q;
    stall_d     = stall_q;
    stall_err_d = stall_err_q;

    // Video during the start-position load sees an empty board.
    if (bus.vid_req) begin
      vid_data_d = in_run ? mem_q[bus.vid_addr] : 4'h0;
    end
    if (gl_grant && !bus.gl_we) begin
      gl_rdata_d = mem_q[bus.gl_addr];
    end

    if (!bus.gl_req || gl_grant) begin
      stall_d = '0;
    end else if (stall_q != STALL_MAX) begin
      stall_d = stall_q + 1'b1;
    end
    if (stall_d == STALL_MAX) begin
      stall_err_d = 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      gl_ack_q    <= 1'b0;
      gl_rdata_q  <= '0;
      stall_q     <= '0;
      stall_err_q <= 1'b0;
    end else begin
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      gl_ack_q    <= gl_ack_d;
      gl_rdata_q  <= gl_rdata_d;
      stall_q     <= stall_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign bus.vid_valid    = vid_valid_q;
  assign bus.vid_data     = vid_data_q;
  assign bus.gl_ack       = gl_ack_q;
  assign bus.gl_rdata     = gl_rdata_q;
  assign bus.gl_stall_err = stall_err_q;

  ack_is_pulse: assert property (@(posedge vga_clk) disable iff (reset)
    gl_ack_q |=> !gl_ack_q);

  // A waiting game request may be abandoned, but not altered.
  gl_inputs_held: assert property (@(posedge vga_clk) disable iff (reset)
    (bus.gl_req && !gl_ack_q && !gl_grant)
      |=> (!bus.gl_req || $stable({bus.gl_we, bus.gl_addr, bus.gl_wdata})));

endmodule
